// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module  : mdu_ctrl
// Brief   : MIPS multiply/divide controller. Holds busy for a fixed latency,
//           then commits the 64-bit result to HI/LO. Macro MDU_MADD_EN enables
//           MADD/MADDU accumulation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int CNT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic [0:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          is_mul, is_div, launch, done;
  logic          mthi_we, mtlo_we, hilo_we;
  logic [63:0]   hilo_next;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag, sq, sr, uq, ur;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (mdu_op)
      OP_MULT, OP_MULTU: is_mul = 1'b1;
      OP_MADD, OP_MADDU: is_mul = MADD_EN;
      OP_DIV,  OP_DIVU:  is_div = 1'b1;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next == S_BUSY);
    end
  end

  // Next-state logic; flush beats both start and completion
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    launch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !flush && (is_mul || is_div)) begin
          launch     = 1'b1;
          state_next = S_BUSY;
          cnt_next   = is_div ? DIV_CNT : MUL_CNT;
        end
      end
      S_BUSY: begin
        if (flush || cnt == CNT_ONE) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow traps
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    sq     = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    sr     = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    uq     = a_q / b_q;
    ur     = a_q % b_q;
  end

  // Output logic: HI/LO write strobes and commit value
  always_comb begin
    done      = (state == S_BUSY) && !flush && (cnt == CNT_ONE);
    mthi_we   = (state == S_IDLE) && start && !flush && (mdu_op == OP_MTHI);
    mtlo_we   = (state == S_IDLE) && start && !flush && (mdu_op == OP_MTLO);
    hilo_we   = 1'b0;
    hilo_next = {hi, lo};
    if (done) begin
      case (op_q)
        OP_MULT:  begin hilo_we = 1'b1; hilo_next = prod_s; end
        OP_MULTU: begin hilo_we = 1'b1; hilo_next = prod_u; end
        OP_DIV:   begin hilo_we = (b_q != 32'd0); hilo_next = {sr, sq}; end
        OP_DIVU:  begin hilo_we = (b_q != 32'd0); hilo_next = {ur, uq}; end
`ifdef MDU_MADD_EN
        OP_MADD:  begin hilo_we = 1'b1; hilo_next = {hi, lo} + prod_s; end
        OP_MADDU: begin hilo_we = 1'b1; hilo_next = {hi, lo} + prod_u; end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      if (launch) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= mdu_op;
      end
      if (hilo_we) begin
        {hi, lo} <= hilo_next;
      end else begin
        if (mthi_we) hi <= A;
        if (mtlo_we) lo <= A;
      end
    end
  end

  assign rdata = rd_hi ? hi : lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module  : tb_mdu_ctrl
// Brief   : Directed self-checking bench for mdu_ctrl (MUL_LAT=5, DIV_LAT=10).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        flush = 1'b0;
  logic        rd_hi = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, rdata;

  int errors = 0;
  int checks = 0;

  mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .flush(flush), .rd_hi(rd_hi),
    .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdu_op = op; A = a; B = b;
    step();
    start = 1'b0; mdu_op = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  // Counts busy cycles, starting in the first cycle after the start edge
  task automatic measure_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(posedge clk); #1;
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    measure_busy(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy got=%0d exp=5", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    measure_busy(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy got=%0d exp=5", n); end
    checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL multu_hi got=%h exp=00000002", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    measure_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div_busy got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    measure_busy(n);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
    issue(4'd4, 32'd100, 32'd7);
    measure_busy(n);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got=%h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got=%h exp=00000002", hi); end
    issue(4'd5, 32'h11, 32'd0);
    issue(4'd6, 32'h22, 32'd0);
    issue(4'd4, 32'd7, 32'd0);
    measure_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divz_busy got=%0d exp=10", n); end
    checks++; if (hi !== 32'h11) begin errors++; $display("FAIL divz_hi got=%h exp=00000011", hi); end
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL divz_lo got=%h exp=00000022", lo); end
  endtask

  task automatic test_move();
    int n;
    issue(4'd1, 32'd3, 32'd4);
    issue(4'd5, 32'h1234, 32'd0);
    measure_busy(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL mthi_busy_rest got=%0d exp=4", n); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mthi_ignored_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL mthi_ignored_lo got=%h exp=0000000c", lo); end
    issue(4'd6, 32'hABCD, 32'd0);
    rd_hi = 1'b0;
    #1;
    checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_lo got=%h exp=0000abcd", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got=%h exp=0", busy); end
    checks++; if (rdata !== 32'hABCD) begin errors++; $display("FAIL rdata_lo got=%h exp=0000abcd", rdata); end
    rd_hi = 1'b1;
    #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rdata_hi got=%h exp=0", rdata); end
    rd_hi = 1'b0;
  endtask

  task automatic test_flush();
    issue(4'd5, 32'h55, 32'd0);
    issue(4'd6, 32'h66, 32'd0);
    issue(4'd1, 32'd5, 32'd5);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%h exp=0", busy); end
    checks++; if (hi !== 32'h55) begin errors++; $display("FAIL flush_hi got=%h exp=00000055", hi); end
    checks++; if (lo !== 32'h66) begin errors++; $display("FAIL flush_lo got=%h exp=00000066", lo); end
    repeat (6) step();
    checks++; if (lo !== 32'h66) begin errors++; $display("FAIL flush_late_lo got=%h exp=00000066", lo); end
    flush = 1'b1;
    issue(4'd1, 32'd5, 32'd5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_busy got=%h exp=0", busy); end
    issue(4'd6, 32'h77, 32'd0);
    checks++; if (lo !== 32'h66) begin errors++; $display("FAIL start_flush_mtlo got=%h exp=00000066", lo); end
    flush = 1'b0;
  endtask

  task automatic test_madd();
`ifdef MDU_MADD_EN
    int n;
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    issue(4'd8, 32'd1, 32'd1);
    measure_busy(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL maddu_busy got=%0d exp=5", n); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL maddu_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL maddu_lo got=%h exp=0", lo); end
`else
    issue(4'd5, 32'h99, 32'd0);
    issue(4'd6, 32'h88, 32'd0);
    issue(4'd7, 32'd3, 32'd3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL madd_off_busy got=%h exp=0", busy); end
    step();
    checks++; if (hi !== 32'h99) begin errors++; $display("FAIL madd_off_hi got=%h exp=00000099", hi); end
    checks++; if (lo !== 32'h88) begin errors++; $display("FAIL madd_off_lo got=%h exp=00000088", lo); end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    issue(4'd5, 32'hAA, 32'd0);
    issue(4'd6, 32'hBB, 32'd0);
    issue(4'd3, 32'd100, 32'd3);
    step();
    step();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%h exp=0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
    step();
    reset = 1'b1;
    repeat (12) step();
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_nowrite got=%h exp=0", lo); end
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    measure_busy(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL rstmid_mult_busy got=%0d exp=5", n); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL rstmid_mult got=%h exp=fffffffffffffffa", {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_flush();
    test_madd();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the pipelined MIPS core's execute stage, sitting beside the single-cycle ALU.
- Accepts one mult/div/move-to command per start pulse and holds busy for a fixed latency to model an iterative unit.
- Commits the 64-bit result to the HI/LO registers, and drives the read-back value for MFHI/MFLO.
- The hazard unit stalls the D stage on busy or start.

Parameters:
- MUL_LAT, 5, cycles busy is held for MULT/MULTU/MADD/MADDU (>=1)
- DIV_LAT, 10, cycles busy is held for DIV/DIVU (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  single-cycle command strobe from E stage
- mdu_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; others NONE
- A  input  32  rs operand
- B  input  32  rt operand
- flush  input  1  cancel in-flight op (exception/flush), synchronous
- rd_hi  input  1  1 selects HI, 0 selects LO on rdata
- busy  output  1  registered; high while an op is in flight
- hi  output  32  HI register
- lo  output  32  LO register
- rdata  output  32  combinational: rd_hi ? hi : lo

Behaviour:
- Reset (reset==0, async): state IDLE, counter 0, busy 0, hi 0, lo 0, operand latches 0. Release takes effect at the next clk edge. Reset mid-operation discards the op and leaves no partial HI/LO write.
- States: IDLE, BUSY. The counter is wide enough for max(MUL_LAT, DIV_LAT).
- IDLE + start + mult/div op:
  - At the edge, latch A, B and op; counter <= LAT for the op class; busy <= 1; go BUSY.
  - busy is high for exactly LAT cycles starting the cycle after start.
- IDLE + start + MTHI/MTLO: hi <= A (or lo <= A) at that edge; no busy; stays IDLE.
- start with NONE op: no effect.
- BUSY: counter decrements each edge. At the edge where counter==1:
  - compute from the latched operands and write hi/lo;
  - busy <= 0; go IDLE.
  - The new hi/lo are visible in the first cycle busy is low.
- start while BUSY: ignored entirely, including MTHI/MTLO. The hazard unit must not issue it.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64.
  - MULTU: same, unsigned.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Divide by zero (B==0): busy still runs DIV_LAT cycles; hi/lo unchanged at completion.
- flush:
  - In BUSY: go IDLE at the next edge, busy <= 0, hi/lo unchanged.
  - flush together with start in the same cycle: flush wins, start ignored, including MTHI/MTLO.
  - flush in IDLE: no effect.
- rdata is purely combinational from the current hi/lo. There is no forwarding of an in-flight result.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: MADD does {hi,lo} <= {hi,lo} + signed(A*B); MADDU does the unsigned equivalent. Both use MUL_LAT. The accumulate reads hi/lo at the completion edge, wraps modulo 2^64, and sets no overflow flag.
- Undefined: op codes 7 and 8 decode as NONE (start ignored, busy stays 0). No accumulator adder is synthesised.

Test Plan:
- Reset low mid-DIV, then release -> busy=0, hi=0, lo=0 immediately on assertion; the next MULT runs normally.
- MULT A=0xFFFFFFFE(-2), B=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 after MTHI 0x11, MTLO 0x22 -> hi=0x11, lo=0x22 after 10 busy cycles.
- MTHI 0x1234 while busy from a MULT -> ignored; hi = MULT result. MTLO 0xABCD while idle -> lo=0xABCD the next cycle, busy stays 0, rdata with rd_hi=0 = 0xABCD.
- MULT started, flush in cycle 3 of busy -> busy=0 the next cycle, hi/lo hold prior values. start+flush in the same cycle -> no op accepted.
- With MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0. Without it: op 7 with start -> busy stays 0 and hi/lo are unchanged.
